// File: rtl/sm_noc_ni_rx_if.sv
// Router-to-NI ejection handshake.
// One 128-bit packet moves per cycle when inValid && inReady.
interface sm_noc_ni_rx_if;
  logic         inValid;
  logic         inReady;
  logic [127:0] inData;

  modport master (
    output inValid,
    output inData,
    input  inReady
  );

  modport slave (
    input  inValid,
    input  inData,
    output inReady
  );
endinterface

// File: rtl/sm_noc_ni_rx.sv
// Receive-side NI: dst filter, packet FIFO, CPU register view,
// per-source sequence checking and rx/drop statistics.
module sm_noc_ni_rx #(
  parameter logic [3:0] NODE_ID   = 4'd0,
  parameter int         DEPTH_LOG = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  sm_noc_ni_rx_if.slave       rx,
  input  logic [2:0]          rdAddr,
  output logic [31:0]         rdData,
  input  logic                pop,
  input  logic                clrErr,
  output logic                pktAvail,
  output logic                seqErr
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL =
    {1'b1, {DEPTH_LOG{1'b0}}};

  typedef struct packed {
    logic [3:0]  dst;
    logic [3:0]  src;
    logic [7:0]  seq;
    logic [15:0] rsvd;
    logic [95:0] payload;
  } pkt_t;

  pkt_t                 in_pkt;
  logic [127:0]         mem [DEPTH];
  logic [127:0]         head;
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic [15:0]          rx_cnt;
  logic [7:0]           drop_cnt;
  logic                 seq_err;
  logic [7:0]           exp_seq [16];

  logic xfer;
  logic store;
  logic drop;
  logic do_pop;
  logic bad_seq;

  assign in_pkt   = rx.inData;
  assign rx.inReady = (count != FULL);
  assign xfer     = rx.inValid && rx.inReady;
  assign store    = xfer && (in_pkt.dst == NODE_ID);
  assign drop     = xfer && (in_pkt.dst != NODE_ID);
  assign do_pop   = pop && (count != '0);
  assign bad_seq  = store &&
                    (in_pkt.seq != exp_seq[in_pkt.src]);

  assign pktAvail = (count != '0);
  assign seqErr   = seq_err;
  assign head     = mem[rd_ptr];

  // Packet storage is not reset; stale words stay readable.
  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= rx.inData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store)  wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{DEPTH_LOG{1'b0}}, store}
             - {{DEPTH_LOG{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (store) rx_cnt <= rx_cnt + 16'd1;
      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Expected seq always follows the last stored packet,
  // so one gap raises a single error and then resyncs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_err <= 1'b0;
      for (int i = 0; i < 16; i++) exp_seq[i] <= '0;
    end else begin
      if (bad_seq)     seq_err <= 1'b1;
      else if (clrErr) seq_err <= 1'b0;
      if (store)
        exp_seq[in_pkt.src] <= in_pkt.seq + 8'd1;
    end
  end

  always_comb begin
    rdData = '0;
    case (rdAddr)
      3'd0: rdData = head[127:96];
      3'd1: rdData = head[95:64];
      3'd2: rdData = head[63:32];
      3'd3: rdData = head[31:0];
      3'd4: rdData = {16'b0, 8'(count), 6'b0,
                      seq_err, pktAvail};
      3'd5: rdData = {8'b0, drop_cnt, rx_cnt};
      default: rdData = '0;
    endcase
  end

endmodule
